// File: rtl/sd_sector_uart_tx.sv
// SD sector readback: requests one sector, buffers the bytes in a small FIFO, and sends them as 8N1 UART frames.
// Define SD_SECTOR_UART_CHECKSUM_EN to append a mod-256 sum frame after a complete sector.
module sd_sector_uart_tx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int FIFO_DEPTH   = 16,
    parameter int SECTOR_BYTES = 512
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [31:0] sector_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        rd_start,
    output logic [31:0] rd_addr,
    input  logic [7:0]  rd_data,
    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic        rd_err,
    output logic        tx
);
    localparam int              BAUD_DIV   = CLK_FREQ / BAUD;
    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam int              DW         = $clog2(BAUD_DIV);
    localparam logic [10:0]     LAST_COUNT = 11'(SECTOR_BYTES);
    localparam logic [DW-1:0]   BAUD_LAST  = DW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
`ifdef SD_SECTOR_UART_CHECKSUM_EN
        CKSUM  = 3'd4,
`endif
        FIN    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q;
    logic          err_q;
    logic [10:0]   count_q;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full, push, pop, flush;

    logic          ser_active_q, tx_q;
    logic [8:0]    shift_q;
    logic [3:0]    bit_cnt_q;
    logic [DW-1:0] baud_cnt_q;
    logic          ser_last, ser_avail, ser_load;
    logic [7:0]    ser_byte;
`ifdef SD_SECTOR_UART_CHECKSUM_EN
    logic [7:0]    sum_q;
    logic          cksum_load;
`endif

    // Extra pointer MSB tells full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_ready = (state_q == STREAM) && !rd_err && !fifo_full && (count_q < LAST_COUNT);
    assign push     = rd_valid && rd_ready;
    assign flush    = (state_q == STREAM) && rd_err;

    // Serializer can take a new byte on the last stop-bit cycle, so frames run back-to-back.
    assign ser_last  = ser_active_q && (bit_cnt_q == 4'd9) && (baud_cnt_q == BAUD_LAST);
    assign ser_avail = !ser_active_q || ser_last;
    assign pop       = (((state_q == STREAM) && !rd_err) || (state_q == DRAIN)) && ser_avail && !fifo_empty;

`ifdef SD_SECTOR_UART_CHECKSUM_EN
    assign cksum_load = (state_q == DRAIN) && fifo_empty && ser_avail;
    assign ser_load   = pop || cksum_load;
    assign ser_byte   = cksum_load ? sum_q : mem[rd_ptr_q[AW-1:0]];
`else
    assign ser_load   = pop;
    assign ser_byte   = mem[rd_ptr_q[AW-1:0]];
`endif

    assign busy     = (state_q != IDLE);
    assign rd_start = (state_q == REQ);
    assign done     = (state_q == FIN) && !ser_active_q;
    assign err      = err_q;
    assign rd_addr  = addr_q;
    assign tx       = tx_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = REQ;
            REQ:    state_d = STREAM;
            STREAM: begin
                if (rd_err)                      state_d = FIN;
                else if (count_q == LAST_COUNT)  state_d = DRAIN;
            end
`ifdef SD_SECTOR_UART_CHECKSUM_EN
            DRAIN:  if (cksum_load) state_d = CKSUM;
            CKSUM:  if (!ser_active_q) state_d = FIN;
`else
            DRAIN:  if (fifo_empty && !ser_active_q) state_d = FIN;
`endif
            FIN:    if (!ser_active_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
`ifdef SD_SECTOR_UART_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && start) begin
                addr_q  <= sector_addr;
                err_q   <= 1'b0;
                count_q <= '0;
`ifdef SD_SECTOR_UART_CHECKSUM_EN
                sum_q   <= '0;
`endif
            end
            if (push) begin
                count_q <= count_q + 11'd1;
`ifdef SD_SECTOR_UART_CHECKSUM_EN
                sum_q   <= sum_q + rd_data;
`endif
            end
            if (flush) err_q <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (flush)    rd_ptr_q <= wr_ptr_q;
            else if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= rd_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ser_active_q <= 1'b0;
            tx_q         <= 1'b1;
            shift_q      <= '1;
            bit_cnt_q    <= '0;
            baud_cnt_q   <= '0;
        end else if (ser_load) begin
            ser_active_q <= 1'b1;
            tx_q         <= 1'b0;
            shift_q      <= {1'b1, ser_byte};
            bit_cnt_q    <= '0;
            baud_cnt_q   <= '0;
        end else if (ser_active_q) begin
            if (baud_cnt_q == BAUD_LAST) begin
                baud_cnt_q <= '0;
                if (bit_cnt_q == 4'd9) begin
                    ser_active_q <= 1'b0;
                    tx_q         <= 1'b1;
                end else begin
                    tx_q      <= shift_q[0];
                    shift_q   <= {1'b1, shift_q[8:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else begin
                baud_cnt_q <= baud_cnt_q + 1'b1;
            end
        end
    end

endmodule
